queue_ctrl: RTL and testbench
=============================

// Module: queue_ctrl
// PURPOSE
//  Sequencer between deserializer, 8-entry queue and downstream consumer. Converts data_ready_des
//  level and deq_req level into single-cycle enq/deq strobes, one operation in flight at a time.
//  Never strobes enq and deq in the same cycle, so len_q always stays consistent.
//  Arbitrates between them round-robin. Captures dequeued bytes with a valid pulse.
//  Flags overflow and ack timeouts.
// PARAMETERS
//  DEPTH        8   queue capacity; enq granted only while len_q < DEPTH
//  ACK_TIMEOUT  4   cycles in ENQ_WAIT without ack_in_q before abort
//  DRAIN_THRESH 6   len_q level that triggers auto-drain (QUEUE_CTRL_AUTODRAIN_EN only)
// PORTS
//  clock_10k      in   1  single clock, 10 kHz
//  reset          in   1  synchronous, active-high
//  data_ready_des in   1  deserializer byte ready; level, held until ack_des
//  ack_des        out  1  1-cycle pulse: byte accepted by queue
//  enq_q          out  1  enqueue strobe to queue
//  ack_in_q       in   1  queue enqueue ack
//  deq_q          out  1  dequeue strobe to queue
//  q_data         in   8  queue data_out
//  len_q          in   4  queue occupancy 0..8
//  status_q       in   1  queue full-error pulse
//  deq_req        in   1  consumer wants a byte; level
//  data_out       out  8  last dequeued byte; held until next dequeue
//  data_valid     out  1  1-cycle pulse: data_out updated
//  busy           out  1  state != IDLE
//  err_overflow   out  1  sticky: status_q seen high
//  err_timeout    out  1  sticky: ENQ_WAIT timed out
//  err_clear      in   1  clears both sticky flags (reset has priority)
// BEHAVIOUR
//  - Sync reset: state=IDLE, last_grant=DEQ, timer=0, all outputs 0 incl. data_out; in-flight op dropped.
//  - All outputs registered. enq_q is high only in ENQ, deq_q only in DEQ, busy = !IDLE.
//  - enq_pend = data_ready_des & len_q<DEPTH & !ack_des. deq_pend = deq_req & len_q>0.
//  - IDLE: both pending -> grant opposite of last_grant. One pending -> grant it.
//    Grant -> ENQ or DEQ next cycle; last_grant updated.
//  - ENQ (1 cycle): enq_q=1 -> ENQ_WAIT, timer=0.
//  - ENQ_WAIT: ack_in_q=1 -> ack_des=1 next cycle, go IDLE.
//    Else timer++; timer==ACK_TIMEOUT-1 -> err_timeout=1, IDLE, no ack_des.
//  - DEQ (1 cycle): deq_q=1 -> DEQ_WAIT.
//  - DEQ_WAIT (1 cycle): data_out<=q_data, data_valid=1 next cycle; -> IDLE.
//  - Latency: grant edge -> enq_q +1 -> ack_in_q +2 -> ack_des +3.
//    Dequeue: grant -> deq_q +1 -> data_valid +3.
//  - Min op spacing 3 cycles (ENQ/DEQ, WAIT, IDLE). IDLE always lasts >=1 cycle.
//  - Full (len_q==DEPTH): enq held off; data_ready_des simply waits (backpressure), no error.
//  - Empty (len_q==0): deq_req ignored; no strobe, no data_valid.
//  - status_q=1 in any state sets err_overflow; otherwise ignored.
//  - err_clear and status_q in same cycle: err_overflow stays set.
//  - Deasserting data_ready_des/deq_req after grant does not cancel the op.
//  - ack_des and data_valid never overlap enq_q/deq_q of the next op.
// CONFIGURATION
//  QUEUE_CTRL_AUTODRAIN_EN defined:
//    In IDLE, len_q>=DRAIN_THRESH forces a deq grant regardless of deq_req and round-robin.
//    Output is identical to a requested dequeue (data_valid pulses).
//  QUEUE_CTRL_AUTODRAIN_EN undefined: dequeue only on deq_req; DRAIN_THRESH unused.
// TESTING
//  1 reset mid-ENQ_WAIT -> next cycle IDLE, all outputs 0, no ack_des.
//  2 data_ready_des=1, ack_in_q 1 cycle after enq_q -> enq_q cyc1, ack_des cyc3, len 0->1.
//  3 data_ready_des & deq_req held, len_q=4 -> strobes alternate ENQ,DEQ,ENQ..., never same cycle.
//  4 Queue returns 0xA5 on deq -> data_out=0xA5 with data_valid pulse 3 cycles after grant.
//  5 len_q=8 with data_ready_des=1 -> no enq_q, no error; deq_req makes len 7, then enq proceeds.
//  6 ack_in_q stuck 0 -> err_timeout=1 after 4 WAIT cycles; err_clear -> 0.
//    With AUTODRAIN_EN: len_q=6, deq_req=0 -> deq_q issued.

Source files
------------

// File: rtl/queue_ctrl_if.sv
// queue_ctrl_if: bundles the handshake signals between the queue sequencer
// and its neighbours (deserializer, 8-entry queue, downstream consumer).
// The master modport is the sequencer's view; slave is the environment's view.
interface queue_ctrl_if;
    logic       data_ready_des;
    logic       ack_des;
    logic       enq_q;
    logic       ack_in_q;
    logic       deq_q;
    logic [7:0] q_data;
    logic [3:0] len_q;
    logic       status_q;
    logic       deq_req;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       err_overflow;
    logic       err_timeout;
    logic       err_clear;

    modport master (
        input  data_ready_des, ack_in_q, q_data, len_q, status_q, deq_req, err_clear,
        output ack_des, enq_q, deq_q, data_out, data_valid, busy, err_overflow, err_timeout
    );

    modport slave (
        output data_ready_des, ack_in_q, q_data, len_q, status_q, deq_req, err_clear,
        input  ack_des, enq_q, deq_q, data_out, data_valid, busy, err_overflow, err_timeout
    );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl: sequencer between a deserializer, an 8-entry queue and a
// downstream consumer. Turns the data_ready_des / deq_req levels into
// single-cycle enq_q / deq_q strobes with one operation in flight, arbitrates
// round-robin, captures dequeued bytes with a data_valid pulse and keeps
// sticky overflow / ack-timeout flags. All outputs are registered.
//
// Optional feature: define QUEUE_CTRL_AUTODRAIN_EN to force a dequeue grant
// from IDLE whenever len_q >= DRAIN_THRESH, independent of deq_req.
module queue_ctrl #(
    parameter int DEPTH        = 8,
    parameter int ACK_TIMEOUT  = 4,
    parameter int DRAIN_THRESH = 6
) (
    input  logic          clock_10k,
    input  logic          reset,
    queue_ctrl_if.master  bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENQ      = 3'd1;
    localparam logic [2:0] ST_ENQ_WAIT = 3'd2;
    localparam logic [2:0] ST_DEQ      = 3'd3;
    localparam logic [2:0] ST_DEQ_WAIT = 3'd4;

    localparam logic GRANT_ENQ = 1'b0;
    localparam logic GRANT_DEQ = 1'b1;

    localparam int              TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       DEPTH_L  = 4'(DEPTH);

    // len_q is 4 bits wide and the drain level must be reachable
    if (DEPTH < 1 || DEPTH > 15 || ACK_TIMEOUT < 1 ||
        DRAIN_THRESH < 1 || DRAIN_THRESH > DEPTH) begin : g_bad_params
        $error("queue_ctrl: illegal parameter combination");
    end

`ifdef QUEUE_CTRL_AUTODRAIN_EN
    localparam logic [3:0] DRAIN_L = 4'(DRAIN_THRESH);
    logic drain_s;
`endif

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic             last_grant_r;
    logic             last_grant_nx_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nx_s;

    logic       enq_pend_s;
    logic       deq_pend_s;
    logic       pick_enq_s;
    logic       pick_deq_s;
    logic       timeout_s;
    logic       ack_set_s;
    logic       val_set_s;

    logic       ack_des_r;
    logic       enq_q_r;
    logic       deq_q_r;
    logic [7:0] data_out_r;
    logic       data_valid_r;
    logic       busy_r;
    logic       err_overflow_r;
    logic       err_timeout_r;

    assign bus.ack_des      = ack_des_r;
    assign bus.enq_q        = enq_q_r;
    assign bus.deq_q        = deq_q_r;
    assign bus.data_out     = data_out_r;
    assign bus.data_valid   = data_valid_r;
    assign bus.busy         = busy_r;
    assign bus.err_overflow = err_overflow_r;
    assign bus.err_timeout  = err_timeout_r;

    // Request qualification: ack_des masks the byte that was just accepted
    // so the still-high data_ready_des level is not granted twice.
    always_comb begin
        enq_pend_s = bus.data_ready_des && (bus.len_q < DEPTH_L) && !ack_des_r;
        deq_pend_s = bus.deq_req && (bus.len_q != 4'd0);
`ifdef QUEUE_CTRL_AUTODRAIN_EN
        drain_s    = (bus.len_q >= DRAIN_L);
`endif
    end

    // Round-robin arbitration between pending enqueue and dequeue
    always_comb begin
        pick_enq_s = 1'b0;
        pick_deq_s = 1'b0;
`ifdef QUEUE_CTRL_AUTODRAIN_EN
        if (drain_s) begin
            pick_deq_s = 1'b1;
        end else
`endif
        if (enq_pend_s && deq_pend_s) begin
            if (last_grant_r == GRANT_DEQ) begin
                pick_enq_s = 1'b1;
            end else begin
                pick_deq_s = 1'b1;
            end
        end else if (enq_pend_s) begin
            pick_enq_s = 1'b1;
        end else if (deq_pend_s) begin
            pick_deq_s = 1'b1;
        end else begin
            pick_enq_s = 1'b0;
            pick_deq_s = 1'b0;
        end
    end

    // Next-state, grant history and ack timer
    always_comb begin
        state_nx_s      = state_r;
        last_grant_nx_s = last_grant_r;
        timer_nx_s      = timer_r;
        timeout_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_enq_s) begin
                    state_nx_s      = ST_ENQ;
                    last_grant_nx_s = GRANT_ENQ;
                end else if (pick_deq_s) begin
                    state_nx_s      = ST_DEQ;
                    last_grant_nx_s = GRANT_DEQ;
                end else begin
                    state_nx_s      = ST_IDLE;
                end
            end
            ST_ENQ: begin
                state_nx_s = ST_ENQ_WAIT;
                timer_nx_s = '0;
            end
            ST_ENQ_WAIT: begin
                if (bus.ack_in_q) begin
                    state_nx_s = ST_IDLE;
                end else if (timer_r == TMR_LAST) begin
                    state_nx_s = ST_IDLE;
                    timeout_s  = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TMR_W'(1);
                end
            end
            ST_DEQ: begin
                state_nx_s = ST_DEQ_WAIT;
            end
            ST_DEQ_WAIT: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        ack_set_s = (state_r == ST_ENQ_WAIT) && bus.ack_in_q;
        val_set_s = (state_r == ST_DEQ_WAIT);
    end

    // State register; reset drops any in-flight operation
    always_ff @(posedge clock_10k) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_DEQ;
            timer_r      <= '0;
        end else begin
            state_r      <= state_nx_s;
            last_grant_r <= last_grant_nx_s;
            timer_r      <= timer_nx_s;
        end
    end

    // Registered strobes decoded from the next state so they align with it
    always_ff @(posedge clock_10k) begin
        if (reset) begin
            enq_q_r      <= 1'b0;
            deq_q_r      <= 1'b0;
            busy_r       <= 1'b0;
            ack_des_r    <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            enq_q_r      <= (state_nx_s == ST_ENQ);
            deq_q_r      <= (state_nx_s == ST_DEQ);
            busy_r       <= (state_nx_s != ST_IDLE);
            ack_des_r    <= ack_set_s;
            data_valid_r <= val_set_s;
        end
    end

    // Capture the dequeued byte; held until the next dequeue
    always_ff @(posedge clock_10k) begin
        if (reset) begin
            data_out_r <= 8'h00;
        end else if (val_set_s) begin
            data_out_r <= bus.q_data;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    // Sticky error flags; a new error event wins over err_clear
    always_ff @(posedge clock_10k) begin
        if (reset) begin
            err_overflow_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            if (bus.status_q) begin
                err_overflow_r <= 1'b1;
            end else if (bus.err_clear) begin
                err_overflow_r <= 1'b0;
            end else begin
                err_overflow_r <= err_overflow_r;
            end
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end else if (bus.err_clear) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
        end
    end

endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: directed bench for queue_ctrl. Stimulus pushes the expected
// strobe/pulse events (kind, cycle, data) into a scoreboard queue; a monitor
// pops and compares whenever the DUT raises enq_q, deq_q, ack_des or
// data_valid. A small queue model answers enq_q with ack_in_q one cycle later
// and deq_q with q_data. Level outputs are checked directly.
module tb_queue_ctrl;

    localparam int EV_ENQ = 0;
    localparam int EV_DEQ = 1;
    localparam int EV_ACK = 2;
    localparam int EV_VAL = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic clock_10k = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    ev_t        exp_q[$];
    logic [7:0] qmem[$];
    logic [7:0] des_byte;
    logic       ack_en;
    logic       ack_pend;
    int         c;

    queue_ctrl_if bus ();

    queue_ctrl u_dut (
        .clock_10k (clock_10k),
        .reset     (reset),
        .bus       (bus.master)
    );

    always #50 clock_10k = ~clock_10k;

    always @(posedge clock_10k) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_chk(input int kind, input logic [7:0] d);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: event kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data !== d) begin
                n_err++;
                $display("FAIL sb_event: got kind %0d cyc %0d data %02h, required kind %0d cyc %0d data %02h",
                         kind, cyc, d, e.kind, e.cyc, e.data);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_10k);
        #1;
    endtask

    // Monitor: compare every presented strobe/pulse against the scoreboard
    initial begin
        forever begin
            @(negedge clock_10k);
            if (bus.enq_q === 1'b1 && bus.deq_q === 1'b1) begin
                n_chk++;
                n_err++;
                $display("FAIL strobe_overlap: enq_q=1 and deq_q=1 at cycle %0d, required at most one", cyc);
            end
            if (bus.enq_q === 1'b1)      sb_chk(EV_ENQ, 8'h00);
            if (bus.deq_q === 1'b1)      sb_chk(EV_DEQ, 8'h00);
            if (bus.ack_des === 1'b1)    sb_chk(EV_ACK, 8'h00);
            if (bus.data_valid === 1'b1) sb_chk(EV_VAL, bus.data_out);
        end
    end

    // Queue model: ack one cycle after enq_q, present data after deq_q
    initial begin
        bus.ack_in_q = 1'b0;
        bus.q_data   = 8'h00;
        bus.len_q    = 4'd0;
        ack_pend     = 1'b0;
        forever begin
            @(negedge clock_10k);
            bus.ack_in_q = ack_pend;
            if (ack_pend) qmem.push_back(des_byte);
            ack_pend = (bus.enq_q === 1'b1) && ack_en;
            if (bus.deq_q === 1'b1 && qmem.size() > 0) bus.q_data = qmem.pop_front();
            bus.len_q = 4'(qmem.size());
        end
    end

    // Directed stimulus
    initial begin
        reset              = 1'b1;
        bus.data_ready_des = 1'b0;
        bus.deq_req        = 1'b0;
        bus.status_q       = 1'b0;
        bus.err_clear      = 1'b0;
        ack_en             = 1'b1;
        des_byte           = 8'h00;

        // Reset state
        step(3);
        chk("reset_outs", 32'({bus.ack_des, bus.enq_q, bus.deq_q, bus.data_valid,
                               bus.busy, bus.err_overflow, bus.err_timeout}), 32'd0);
        chk("reset_data_out", 32'(bus.data_out), 32'd0);
        reset = 1'b0;
        step(2);

        // Single enqueue: enq_q cycle 1, ack_des cycle 3
        des_byte = 8'hA5;
        c = cyc;
        bus.data_ready_des = 1'b1;
        expect_ev(EV_ENQ, c + 1, 8'h00);
        expect_ev(EV_ACK, c + 3, 8'h00);
        step(3);
        bus.data_ready_des = 1'b0;
        step(2);

        // Dequeue returns 0xA5; request dropped after grant
        c = cyc;
        bus.deq_req = 1'b1;
        expect_ev(EV_DEQ, c + 1, 8'h00);
        expect_ev(EV_VAL, c + 3, 8'hA5);
        step(1);
        bus.deq_req = 1'b0;
        step(3);
        chk("data_out_held", 32'(bus.data_out), 32'h0000_00A5);
        step(1);

        // Reset in the middle of ENQ_WAIT
        ack_en = 1'b0;
        c = cyc;
        bus.data_ready_des = 1'b1;
        expect_ev(EV_ENQ, c + 1, 8'h00);
        step(3);
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        bus.data_ready_des = 1'b0;
        step(1);
        chk("midreset_outs", 32'({bus.ack_des, bus.enq_q, bus.deq_q, bus.data_valid,
                                  bus.busy, bus.err_overflow, bus.err_timeout}), 32'd0);
        chk("midreset_data_out", 32'(bus.data_out), 32'd0);
        reset = 1'b0;
        step(5);
        chk("midreset_no_timeout", 32'(bus.err_timeout), 32'd0);
        ack_en = 1'b1;

        // Both pending, len 4: ENQ, DEQ, ENQ, DEQ
        qmem.push_back(8'h10);
        qmem.push_back(8'h11);
        qmem.push_back(8'h12);
        qmem.push_back(8'h13);
        step(1);
        des_byte = 8'h3C;
        c = cyc;
        bus.data_ready_des = 1'b1;
        bus.deq_req        = 1'b1;
        expect_ev(EV_ENQ, c + 1,  8'h00);
        expect_ev(EV_ACK, c + 3,  8'h00);
        expect_ev(EV_DEQ, c + 4,  8'h00);
        expect_ev(EV_VAL, c + 6,  8'h10);
        expect_ev(EV_ENQ, c + 7,  8'h00);
        expect_ev(EV_ACK, c + 9,  8'h00);
        expect_ev(EV_DEQ, c + 10, 8'h00);
        expect_ev(EV_VAL, c + 12, 8'h11);
        step(12);
        bus.data_ready_des = 1'b0;
        bus.deq_req        = 1'b0;
        step(3);

`ifdef QUEUE_CTRL_AUTODRAIN_EN
        // Auto-drain: len reaches 6 with no deq_req
        qmem.push_back(8'h61);
        qmem.push_back(8'h62);
        c = cyc;
        expect_ev(EV_DEQ, c + 2, 8'h00);
        expect_ev(EV_VAL, c + 4, 8'h12);
        step(6);
`else
        // Full queue: enqueue held off without error until a dequeue
        qmem.push_back(8'h50);
        qmem.push_back(8'h51);
        qmem.push_back(8'h52);
        qmem.push_back(8'h53);
        step(1);
        des_byte = 8'h77;
        c = cyc;
        bus.data_ready_des = 1'b1;
        step(5);
        chk("full_no_ovf", 32'(bus.err_overflow), 32'd0);
        chk("full_no_tmo", 32'(bus.err_timeout), 32'd0);
        chk("full_idle", 32'(bus.busy), 32'd0);
        bus.deq_req = 1'b1;
        expect_ev(EV_DEQ, c + 6,  8'h00);
        expect_ev(EV_VAL, c + 8,  8'h12);
        expect_ev(EV_ENQ, c + 9,  8'h00);
        expect_ev(EV_ACK, c + 11, 8'h00);
        step(1);
        bus.deq_req = 1'b0;
        step(5);
        bus.data_ready_des = 1'b0;
        step(3);
`endif

        // Ack never arrives: timeout after 4 WAIT cycles, then clear
        qmem.delete();
        step(1);
        ack_en = 1'b0;
        c = cyc;
        bus.data_ready_des = 1'b1;
        expect_ev(EV_ENQ, c + 1, 8'h00);
        step(5);
        chk("tmo_not_early", 32'(bus.err_timeout), 32'd0);
        chk("tmo_busy", 32'(bus.busy), 32'd1);
        step(1);
        chk("tmo_set", 32'(bus.err_timeout), 32'd1);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
        bus.data_ready_des = 1'b0;
        step(1);
        bus.err_clear = 1'b1;
        step(1);
        bus.err_clear = 1'b0;
        chk("tmo_cleared", 32'(bus.err_timeout), 32'd0);
        ack_en = 1'b1;

        // Overflow flag: set, survives simultaneous clear, then clears
        bus.status_q = 1'b1;
        step(1);
        chk("ovf_set", 32'(bus.err_overflow), 32'd1);
        bus.err_clear = 1'b1;
        step(1);
        chk("ovf_clear_vs_status", 32'(bus.err_overflow), 32'd1);
        bus.status_q = 1'b0;
        step(1);
        chk("ovf_cleared", 32'(bus.err_overflow), 32'd0);
        bus.err_clear = 1'b0;
        step(3);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
